// File: rtl/icache_direct_mapped_if.sv
// icache_direct_mapped_if: CPU fetch port plus block-wide instruction memory port.
// The cache connects through the slave modport. The fetch/memory side uses the master modport.
interface icache_direct_mapped_if #(
    parameter int ADDR_BITS = 10
);
    logic [31:0]          PC;
    logic [31:0]          INSTRUCTION;
    logic                 IBUSYWAIT;
    logic                 MEM_READ;
    logic [ADDR_BITS-5:0] MEM_ADDRESS;
    logic [127:0]         MEM_READDATA;
    logic                 MEM_BUSYWAIT;

    modport master (
        output PC, MEM_READDATA, MEM_BUSYWAIT,
        input  INSTRUCTION, IBUSYWAIT, MEM_READ, MEM_ADDRESS
    );

    modport slave (
        input  PC, MEM_READDATA, MEM_BUSYWAIT,
        output INSTRUCTION, IBUSYWAIT, MEM_READ, MEM_ADDRESS
    );
endinterface

// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: direct-mapped, read-only instruction cache with 16-byte blocks.
// Hits are served combinationally. A miss stalls the CPU, fetches one block, and then replays as a hit.
// Optional feature: define ICACHE_STATS_EN to add the saturating HIT_COUNT/MISS_COUNT outputs.
module icache_direct_mapped #(
    parameter int ADDR_BITS  = 10,
    parameter int INDEX_BITS = 3
) (
    input  logic CLK,
    input  logic RESET,
    icache_direct_mapped_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);
    localparam int          NUM_BLOCKS = 2 ** INDEX_BITS;
    localparam int          TAG_BITS   = ADDR_BITS - 4 - INDEX_BITS;
    localparam logic [31:0] PC_NOREQ   = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {IDLE, MEMREAD, UPDATE} state_t;

    state_t                state_q, state_d;
    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TAG_BITS-1:0]   tag_q  [NUM_BLOCKS];
    logic [127:0]          data_q [NUM_BLOCKS];

    logic [INDEX_BITS-1:0] pc_index;
    logic [TAG_BITS-1:0]   pc_tag;
    logic [1:0]            pc_offset;
    logic [127:0]          line;
    logic                  no_req;
    logic                  hit;

    assign pc_offset       = bus.PC[3:2];
    assign pc_index        = bus.PC[4+INDEX_BITS-1:4];
    assign pc_tag          = bus.PC[ADDR_BITS-1:4+INDEX_BITS];
    assign no_req          = (bus.PC == PC_NOREQ);
    assign hit             = !no_req && valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign line            = data_q[pc_index];
    assign bus.MEM_ADDRESS = bus.PC[ADDR_BITS-1:4];

    // State register. Reset abandons any in-flight fill.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and outputs. During reset all outputs are held at their quiet values.
    always_comb begin
        state_d         = state_q;
        bus.MEM_READ    = 1'b0;
        bus.IBUSYWAIT   = 1'b0;
        bus.INSTRUCTION = '0;
        if (!RESET) begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        bus.INSTRUCTION = line[32*pc_offset +: 32];
                    end else if (!no_req) begin
                        bus.IBUSYWAIT = 1'b1;
                        state_d       = MEMREAD;
                    end
                end
                MEMREAD: begin
                    bus.MEM_READ  = 1'b1;
                    bus.IBUSYWAIT = 1'b1;
                    if (!bus.MEM_BUSYWAIT) state_d = UPDATE;
                end
                UPDATE: begin
                    bus.IBUSYWAIT = 1'b1;
                    state_d       = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Valid bits are cleared on reset and set when a block is installed.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                 valid_q           <= '0;
        else if (state_q == UPDATE) valid_q[pc_index] <= 1'b1;
    end

    // Tag and data arrays need no reset because every read is qualified by the valid bit.
    always_ff @(posedge CLK) begin
        if (state_q == UPDATE) begin
            tag_q[pc_index]  <= pc_tag;
            data_q[pc_index] <= bus.MEM_READDATA;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count_q;
    logic [15:0] miss_count_q;

    // Saturating counters. A hit counts once per IDLE cycle, including the replay after a fill.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (state_q == IDLE) begin
            if (hit && hit_count_q != '1) hit_count_q <= hit_count_q + 16'd1;
            if (state_d == MEMREAD && miss_count_q != '1) miss_count_q <= miss_count_q + 16'd1;
        end
    end

    assign HIT_COUNT  = hit_count_q;
    assign MISS_COUNT = miss_count_q;
`endif
endmodule
